bus_dev_fifo: RTL and testbench

- Per-device interface stage between a device and the bus generator/arbiter (bs_gnrtr_n_rbtr); one instance per device port.
- TX queue buffers device packets and presents them to the arbiter through the pndng/D_pop/pop handshake.
- RX queue captures packets the arbiter delivers through push/D_push and holds them until the device reads them.
- Packet format: the top 8 bits carry the destination ID; the remaining bits are payload.

---
 rtl/bus_dev_fifo_if.sv | 10 +
 rtl/bus_dev_fifo.sv | 86 ++++++++
 tb/tb_bus_dev_fifo.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_dev_fifo_if.sv
// bus_dev_fifo_if: arbiter-side handshake between a device FIFO stage and bs_gnrtr_n_rbtr.
interface bus_dev_fifo_if #(parameter int pckg_sz = 16);
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  modport master (output pndng, D_pop, input pop, push, D_push);
  modport slave (input pndng, D_pop, output pop, push, D_push);
endinterface

// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: per-device TX/RX show-ahead queues toward the bus arbiter; define BUS_DEV_ID_FILTER_EN to accept only pushes addressed to id or broadcast.
module bus_dev_fifo_queue #(
  parameter int w     = 16,
  parameter int depth = 8,
  parameter int aw    = (depth > 1) ? $clog2(depth) : 1,
  parameter int cw    = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [w-1:0]  din,
  input  logic          rd,
  output logic [w-1:0]  head,
  output logic [cw-1:0] count,
  output logic          ovf
);
  logic [w-1:0]  mem [depth];
  logic [aw-1:0] wp, rp;
  logic          empty, is_full, do_rd, do_wr;
  assign empty   = count == '0;
  assign is_full = count == cw'(depth);
  assign do_rd   = rd && !empty;
  // a read in the same cycle frees the slot, so a write at full still lands
  assign do_wr   = wr && (!is_full || do_rd);
  assign head    = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_wr) wp <= (wp == aw'(depth - 1)) ? '0 : wp + 1'b1;
      if (do_rd) rp <= (rp == aw'(depth - 1)) ? '0 : rp + 1'b1;
      count <= count + cw'(do_wr) - cw'(do_rd);
      if (wr && !do_wr) ovf <= 1'b1;
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
endmodule

module bus_dev_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'b0000_1111
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_dev_fifo_if.master             bus,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       full,
  output logic                       tx_overflow,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_valid,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic                       rx_overflow
);
  localparam int cw = $clog2(depth + 1);
  if (pckg_sz < 9 || depth < 2) begin : g_bad_cfg
    $error("bus_dev_fifo: pckg_sz must be >= 9 and depth >= 2");
  end
  logic [cw-1:0] tx_count;
  logic          accept;
`ifdef BUS_DEV_ID_FILTER_EN
  assign accept = (bus.D_push[pckg_sz-1 -: 8] == id) || (bus.D_push[pckg_sz-1 -: 8] == broadcast);
`else
  logic [15:0] unused_ids;
  assign unused_ids = {id, broadcast};
  assign accept     = 1'b1;
`endif
  bus_dev_fifo_queue #(.w(pckg_sz), .depth(depth)) tx_q (
    .clk(clk), .reset(reset), .wr(wr_en), .din(wr_data), .rd(bus.pop),
    .head(bus.D_pop), .count(tx_count), .ovf(tx_overflow)
  );
  assign bus.pndng = tx_count != '0;
  assign full      = tx_count == cw'(depth);
  // rejected pushes never reach the queue, so they cannot raise rx_overflow
  bus_dev_fifo_queue #(.w(pckg_sz), .depth(depth)) rx_q (
    .clk(clk), .reset(reset), .wr(bus.push && accept), .din(bus.D_push), .rd(rd_en),
    .head(rd_data), .count(rx_count), .ovf(rx_overflow)
  );
  assign rx_valid = rx_count != '0;
endmodule

// File: tb/tb_bus_dev_fifo.sv
// tb_bus_dev_fifo: directed self-checking bench for bus_dev_fifo with hand-computed expectations.
module tb_bus_dev_fifo;
`ifdef BUS_DEV_ID_FILTER_EN
  localparam logic [7:0] dev_id = 8'd2;
`else
  localparam logic [7:0] dev_id = 8'd0;
`endif
  logic        clk = 1'b0, reset = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, tx_overflow, rx_valid, rx_overflow;
  logic [15:0] rd_data;
  logic [3:0]  rx_count;
  int          checks = 0, errors = 0;
  bus_dev_fifo_if #(.pckg_sz(16)) bus ();
  bus_dev_fifo #(.pckg_sz(16), .depth(8), .id(dev_id)) dut (
    .clk(clk), .reset(reset), .bus(bus), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .tx_overflow(tx_overflow), .rd_en(rd_en), .rd_data(rd_data),
    .rx_valid(rx_valid), .rx_count(rx_count), .rx_overflow(rx_overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.pop = 1'b0;
    bus.push = 1'b0;
    bus.D_push = '0;
    #2;
    check("rst_pndng", bus.pndng, 0);
    check("rst_full", full, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_d_pop", bus.D_pop, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ovf", {tx_overflow, rx_overflow}, 0);
    #10 reset = 1'b1;
    tick;
    wr_en = 1'b1;
    wr_data = 16'h0101;
    check("pndng_before_write", bus.pndng, 0);
    tick;
    check("pndng_after_write", bus.pndng, 1);
    check("d_pop_first", bus.D_pop, 16'h0101);
    wr_data = 16'h0202;
    tick;
    wr_data = 16'h0303;
    tick;
    wr_en = 1'b0;
    check("full_at3", full, 0);
    bus.pop = 1'b1;
    tick;
    check("d_pop_after_pop", bus.D_pop, 16'h0202);
    tick;
    tick;
    bus.pop = 1'b0;
    check("pndng_drained", bus.pndng, 0);
    check("d_pop_drained", bus.D_pop, 0);
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = {i[7:0], i[7:0]};
      tick;
    end
    check("full_at8", full, 1);
    check("tx_ovf_not_yet", tx_overflow, 0);
    wr_data = 16'h0909;
    tick;
    check("tx_ovf_set", tx_overflow, 1);
    check("full_after_drop", full, 1);
    check("head_after_drop", bus.D_pop, 16'h0101);
    wr_data = 16'hAAAA;
    bus.pop = 1'b1;
    tick;
    wr_en = 1'b0;
    check("full_wr_pop", full, 1);
    check("head_wr_pop", bus.D_pop, 16'h0202);
    for (int i = 2; i <= 8; i++) begin
      check("pop_order", bus.D_pop, {16'(i[7:0]) << 8} | 16'(i[7:0]));
      tick;
    end
    check("last_out", bus.D_pop, 16'hAAAA);
    tick;
    bus.pop = 1'b0;
    check("tx_empty_again", bus.pndng, 0);
    check("tx_ovf_sticky", tx_overflow, 1);
    bus.pop = 1'b1;
    tick;
    bus.pop = 1'b0;
    check("empty_pop_pndng", bus.pndng, 0);
    check("empty_pop_d_pop", bus.D_pop, 0);
    check("empty_pop_full", full, 0);
    wr_en = 1'b1;
    wr_data = 16'h0A0A;
    tick;
    wr_en = 1'b0;
    check("after_empty_pop", bus.D_pop, 16'h0A0A);
    bus.pop = 1'b1;
    tick;
    bus.pop = 1'b0;
    check("after_empty_pop_drain", bus.pndng, 0);
    wr_en = 1'b1;
    bus.pop = 1'b1;
    wr_data = 16'h0B0B;
    tick;
    wr_en = 1'b0;
    bus.pop = 1'b0;
    check("empty_wr_pop_pndng", bus.pndng, 1);
    check("empty_wr_pop_data", bus.D_pop, 16'h0B0B);
    bus.pop = 1'b1;
    tick;
    bus.pop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      wr_data = 16'h1000 + 16'(i);
      tick;
      wr_en = 1'b0;
      check("wrap_data", bus.D_pop, 16'h1000 + 16'(i));
      bus.pop = 1'b1;
      tick;
      bus.pop = 1'b0;
    end
    check("wrap_empty", bus.pndng, 0);
    check("rx_empty", rx_valid, 0);
    bus.push = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      bus.D_push = 16'h0F00 | 16'(i);
      tick;
    end
    bus.push = 1'b0;
    check("rx_count_sat", rx_count, 8);
    check("rx_ovf_set", rx_overflow, 1);
    check("rx_head", rd_data, 16'h0F01);
    bus.push = 1'b1;
    bus.D_push = 16'h0F0A;
    rd_en = 1'b1;
    tick;
    bus.push = 1'b0;
    rd_en = 1'b0;
    check("rx_full_push_rd", rx_count, 8);
    check("rx_head_after", rd_data, 16'h0F02);
    rd_en = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      check("rx_order", rd_data, 16'h0F00 | 16'(i));
      tick;
    end
    check("rx_last", rd_data, 16'h0F0A);
    tick;
    tick;
    rd_en = 1'b0;
    check("rx_drained_valid", rx_valid, 0);
    check("rx_drained_count", rx_count, 0);
    check("rx_drained_data", rd_data, 0);
    wr_en = 1'b1;
    wr_data = 16'h5555;
    tick;
    wr_en = 1'b0;
    bus.push = 1'b1;
    bus.D_push = 16'h0F33;
    tick;
    bus.push = 1'b0;
    check("pre_rst_pndng", bus.pndng, 1);
    check("pre_rst_rx_valid", rx_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("async_pndng", bus.pndng, 0);
    check("async_d_pop", bus.D_pop, 0);
    check("async_rx", {rx_valid, rx_count}, 0);
    check("async_rd_data", rd_data, 0);
    check("async_ovf", {tx_overflow, rx_overflow}, 0);
    #2 reset = 1'b1;
    tick;
    check("post_rst_pndng", bus.pndng, 0);
    check("post_rst_rx_count", rx_count, 0);
    wr_en = 1'b1;
    wr_data = 16'h1234;
    tick;
    wr_en = 1'b0;
    check("post_rst_write", bus.D_pop, 16'h1234);
    bus.pop = 1'b1;
    tick;
    bus.pop = 1'b0;
    check("post_rst_drain", bus.pndng, 0);
    bus.push = 1'b1;
    bus.D_push = 16'h0255;
    tick;
    bus.D_push = 16'h0F66;
    tick;
    bus.D_push = 16'h0377;
    tick;
    bus.push = 1'b0;
    check("filt_ovf", rx_overflow, 0);
    check("filt_head", rd_data, 16'h0255);
    rd_en = 1'b1;
    tick;
    check("filt_second", rd_data, 16'h0F66);
`ifdef BUS_DEV_ID_FILTER_EN
    check("filt_count", rx_count, 1);
    tick;
    check("filt_dropped", rx_valid, 0);
`else
    check("filt_count", rx_count, 2);
    tick;
    check("filt_third", rd_data, 16'h0377);
    tick;
    check("filt_drained", rx_valid, 0);
`endif
    rd_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
